// File: rtl/queue_pkg.sv
// Shared defaults and sizing helper for the FIFO queue.
package queue_pkg;

    localparam int unsigned WIDTH_DEF     = 32;
    localparam int unsigned ADDR_BITS_DEF = 5;

    // Occupancy needs one extra bit to represent a completely full buffer.
    function automatic int unsigned count_width(input int unsigned addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/queue_ram.sv
// Simple dual-port DEPTH x WIDTH memory: one write port, one registered read port with enable.
module queue_ram #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    // Array contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first on a same-address collision: a full-buffer push+pop returns the oldest word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/queue.sv
// FIFO queue with push/pop strobes and full/empty/count status.
// Optional sticky ovf/udf error flags are built when QUEUE_ERR_EN is defined.
module queue
    import queue_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [WIDTH-1:0]                     d,
    input  logic                                 push,
    input  logic                                 pop,
    output logic [WIDTH-1:0]                     q,
    output logic                                 full,
    output logic                                 empty,
`ifdef QUEUE_ERR_EN
    output logic                                 ovf,
    output logic                                 udf,
`endif
    output logic [count_width(ADDR_BITS)-1:0]    count
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CW    = count_width(ADDR_BITS);

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    // Status decodes straight from the count register; no path from the strobes.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot on the same edge, so push is accepted at full only alongside a pop.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef QUEUE_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end
            if (pop && empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

    queue_ram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (d),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (q)
    );

endmodule

// File: tb/tb_queue.sv
// Directed and random self-checking bench for the queue FIFO.
// Checks the sticky ovf/udf flags too when QUEUE_ERR_EN is defined.
module tb_queue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             empty;
    logic [5:0]       count;
`ifdef QUEUE_ERR_EN
    logic             ovf;
    logic             udf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    queue #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .push  (push),
        .pop   (pop),
        .q     (q),
        .full  (full),
        .empty (empty),
`ifdef QUEUE_ERR_EN
        .ovf   (ovf),
        .udf   (udf),
`endif
        .count (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic r, input logic [WIDTH-1:0] data);
        push = p;
        pop  = r;
        d    = data;
        step();
    endtask

    logic [WIDTH-1:0] mdl[$];
    logic [WIDTH-1:0] exp_q;
    int               bias;
    logic             p;
    logic             r;
    logic             p_ok;
    logic             r_ok;
    logic [WIDTH-1:0] rnd;

    initial begin
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        d     = '0;
        step();
        step();
        reset = 1'b0;

        check("rst_q", q, 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_count", 32'(count), 32'h0);
`ifdef QUEUE_ERR_EN
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_udf", 32'(udf), 32'h0);
`endif

        // Ordering
        for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, WIDTH'(i));
        check("ord_count3", 32'(count), 32'd3);
        check("ord_empty0", 32'(empty), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, '0);
            check("ord_q", q, 32'(i));
        end
        drive(1'b0, 1'b0, '0);
        check("ord_empty_end", 32'(empty), 32'h1);
        check("ord_count_end", 32'(count), 32'h0);

        // Fill, overflow attempt, drain
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, WIDTH'(32'h100 + i));
        check("fill_full", 32'(full), 32'h1);
        check("fill_count", 32'(count), 32'd32);
        drive(1'b1, 1'b0, 32'hDEAD);
        check("ovf_count", 32'(count), 32'd32);
        check("ovf_full", 32'(full), 32'h1);
`ifdef QUEUE_ERR_EN
        check("ovf_flag", 32'(ovf), 32'h1);
`endif
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, '0);
            check("drain_q", q, 32'h100 + 32'(i));
        end
        check("drain_empty", 32'(empty), 32'h1);

        // Simultaneous push and pop at full
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, WIDTH'(32'h200 + i));
        drive(1'b1, 1'b1, 32'hAA);
        check("both_full_q", q, 32'h200);
        check("both_full_count", 32'(count), 32'd32);
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, '0);
            check("both_drain_q", q, 32'h200 + 32'(i));
        end
        drive(1'b0, 1'b1, '0);
        check("both_last_aa", q, 32'hAA);
        check("both_end_count", 32'(count), 32'h0);

        // Pop while empty with push: push accepted, pop ignored
        drive(1'b1, 1'b1, 32'h55);
        check("pe_q_hold", q, 32'hAA);
        check("pe_count", 32'(count), 32'd1);
`ifdef QUEUE_ERR_EN
        check("pe_udf", 32'(udf), 32'h1);
`endif
        drive(1'b0, 1'b1, '0);
        check("pe_pop_q", q, 32'h55);
        check("pe_empty", 32'(empty), 32'h1);

        // Mid-operation reset beats a concurrent push
        for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, WIDTH'(i));
        check("mr_count5", 32'(count), 32'd5);
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h9);
        reset = 1'b0;
        check("mr_count", 32'(count), 32'h0);
        check("mr_q", q, 32'h0);
        check("mr_empty", 32'(empty), 32'h1);
`ifdef QUEUE_ERR_EN
        check("mr_ovf", 32'(ovf), 32'h0);
        check("mr_udf", 32'(udf), 32'h0);
`endif
        drive(1'b1, 1'b0, 32'h7);
        drive(1'b0, 1'b1, '0);
        check("mr_q7", q, 32'h7);
        check("mr_end_count", 32'(count), 32'h0);

        // Random soak against a reference queue
        exp_q = 32'h7;
        bias  = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                case ((c / 500) % 3)
                    0:       bias = 75;
                    1:       bias = 25;
                    default: bias = 50;
                endcase
            end
            p   = ($urandom_range(0, 99) < bias);
            r   = ($urandom_range(0, 99) < (100 - bias));
            rnd = $urandom;
            p_ok = p && ((mdl.size() < DEPTH) || r);
            r_ok = r && (mdl.size() > 0);
            if (r_ok) exp_q = mdl.pop_front();
            if (p_ok) mdl.push_back(rnd);
            drive(p, r, rnd);
            check("soak_q", q, exp_q);
            check("soak_count", 32'(count), 32'(mdl.size()));
            check("soak_count_max", 32'(count <= 6'd32), 32'h1);
        end

        push = 1'b0;
        pop  = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
